// File: rtl/cpu_pkg.sv
// Shared types for the CPU slice: sequencer states, halt causes and
// the instruction-address alignment constant.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_PAUSE,
        S_RUN,
        S_STEP,
        S_HALT,
        S_FAULT
    } seq_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'b00,
        CAUSE_SELF_LOOP = 2'b01,
        CAUSE_BUDGET    = 2'b10
    } halt_cause_t;

    localparam logic [1:0] ALIGN_MASK = 2'b00;

endpackage

// File: rtl/pc_sequencer.sv
// Program counter and run control in front of the single-cycle datapath.
// Decides per cycle whether the instruction at pc_out commits.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] MAX_INSTR = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic        pause_req,
    input  logic [31:0] next_pc,
    output logic [31:0] pc_out,
    output logic        cpu_en,
    output logic        running,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  halt_cause,
    output logic [31:0] instr_cnt
);

    seq_state_t  state_q, state_n;
    halt_cause_t cause_q, cause_n;
    logic [31:0] pc_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_inc;
    logic        active;
    logic        aligned;

    assign cnt_inc = cnt_q + 32'd1;
    assign active  = (state_q == S_RUN) || (state_q == S_STEP);
    assign aligned = (next_pc[1:0] == ALIGN_MASK);
    assign cpu_en  = active && !pause_req && aligned;

    always_comb begin
        state_n = state_q;
        cause_n = cause_q;
        unique case (state_q)
            S_PAUSE: begin
                if (start)     state_n = S_RUN;
                else if (step) state_n = S_STEP;
            end
            S_RUN, S_STEP: begin
                if (pause_req) begin
                    state_n = S_PAUSE;
                end else if (!aligned) begin
                    state_n = S_FAULT;
                end else if (next_pc == pc_q) begin
                    // jump-to-self marks the end of a program
                    state_n = S_HALT;
                    cause_n = CAUSE_SELF_LOOP;
                end else if (MAX_INSTR != 32'd0 && cnt_inc == MAX_INSTR) begin
                    state_n = S_HALT;
                    cause_n = CAUSE_BUDGET;
                end else if (state_q == S_STEP) begin
                    state_n = S_PAUSE;
                end
            end
            S_HALT, S_FAULT: begin
                state_n = state_q;
            end
            default: begin
                state_n = S_PAUSE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PAUSE;
            cause_q <= CAUSE_NONE;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_n;
            cause_q <= cause_n;
            if (cpu_en) begin
                pc_q  <= next_pc;
                cnt_q <= cnt_inc;
            end
        end
    end

    assign pc_out     = pc_q;
    assign instr_cnt  = cnt_q;
    assign running    = active;
    assign halted     = (state_q == S_HALT);
    assign fault      = (state_q == S_FAULT);
    assign halt_cause = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer against a
// cycle-level behavioural model of the run-control rules.
module tb_pc_sequencer;

    localparam int M_PAUSE = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_HALT  = 3;
    localparam int M_FAULT = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        step;
    logic        pause_req;
    logic [31:0] next_pc0;
    logic [31:0] pc0;
    logic        cpu_en0;
    logic        running0;
    logic        halted0;
    logic        fault0;
    logic [1:0]  cause0;
    logic [31:0] cnt0;

    logic [31:0] next_pc2;
    logic [31:0] pc2;
    logic        cpu_en2;
    logic        running2;
    logic        halted2;
    logic        fault2;
    logic [1:0]  cause2;
    logic [31:0] cnt2;

    int n_checks;
    int n_fail;

    // behavioural model of the unlimited-budget instance
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [1:0]  m_cause;

    logic        obs_en;
    logic        obs_en2;
    logic        exp_en;
    logic [31:0] pc_before;

    // three sequential adds, then a jump-to-self at 0x0C
    function automatic logic [31:0] prog(input logic [31:0] p);
        return (p == 32'h0C) ? p : p + 32'd4;
    endfunction

    assign next_pc2 = prog(pc2);

    pc_sequencer #(.RESET_PC(32'h0), .MAX_INSTR(32'd0)) dut (
        .clk(clk), .rst(rst), .start(start), .step(step),
        .pause_req(pause_req), .next_pc(next_pc0), .pc_out(pc0),
        .cpu_en(cpu_en0), .running(running0), .halted(halted0),
        .fault(fault0), .halt_cause(cause0), .instr_cnt(cnt0)
    );

    pc_sequencer #(.RESET_PC(32'h0), .MAX_INSTR(32'd2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .step(step),
        .pause_req(pause_req), .next_pc(next_pc2), .pc_out(pc2),
        .cpu_en(cpu_en2), .running(running2), .halted(halted2),
        .fault(fault2), .halt_cause(cause2), .instr_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input logic r, s, st, pr,
                              input logic [31:0] npc);
        logic [31:0] old_pc;
        if (r) begin
            m_state = M_PAUSE;
            m_pc    = 32'h0;
            m_cnt   = 32'h0;
            m_cause = 2'b00;
        end else if (m_state == M_PAUSE) begin
            if (s)       m_state = M_RUN;
            else if (st) m_state = M_STEP;
        end else if (m_state == M_RUN || m_state == M_STEP) begin
            if (pr) begin
                m_state = M_PAUSE;
            end else if (npc % 4 != 0) begin
                m_state = M_FAULT;
            end else begin
                old_pc = m_pc;
                m_pc   = npc;
                m_cnt  = m_cnt + 1;
                if (npc == old_pc) begin
                    m_state = M_HALT;
                    m_cause = 2'b01;
                end else if (m_state == M_STEP) begin
                    m_state = M_PAUSE;
                end
            end
        end
    endtask

    task automatic tick(input logic r, s, st, pr, input logic use_prog,
                        input logic [31:0] npc);
        logic [31:0] v;
        v = use_prog ? prog(pc0) : npc;
        rst = r; start = s; step = st; pause_req = pr; next_pc0 = v;
        #1;
        obs_en    = cpu_en0;
        obs_en2   = cpu_en2;
        pc_before = pc0;
        exp_en = (m_state == M_RUN || m_state == M_STEP) && !pr
                 && (v % 4 == 0);
        @(posedge clk);
        model_step(r, s, st, pr, v);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; step = 1'b0; pause_req = 1'b0;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 1, 0);
        n_checks++;
        if (pc0 !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc got %h want %h", pc0, 32'h0);
        end
        n_checks++;
        if (cnt0 !== 32'h0) begin
            n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt0);
        end
        n_checks++;
        if ({running0, halted0, fault0, cause0} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 00000",
                     {running0, halted0, fault0, cause0});
        end
        #1;
        n_checks++;
        if (cpu_en0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_en got %b want 0", cpu_en0);
        end
    endtask

    task automatic test_program();
        logic [31:0] seen[$];
        logic [31:0] want[4];
        int guard;
        want = '{32'h0, 32'h4, 32'h8, 32'hC};
        tick(1, 0, 0, 0, 1, 0);
        tick(0, 1, 0, 0, 1, 0);
        n_checks++;
        if (running0 !== 1'b1) begin
            n_fail++; $display("FAIL start_latency running got %b want 1", running0);
        end
        guard = 0;
        while (!halted0 && guard < 20) begin
            tick(0, 0, 0, 0, 1, 0);
            if (obs_en) seen.push_back(pc_before);
            guard++;
        end
        n_checks++;
        if (seen.size() != 4) begin
            n_fail++; $display("FAIL prog_commits got %0d want 4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (seen[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL prog_pc%0d got %h want %h", i, seen[i], want[i]);
                end
            end
        end
        n_checks++;
        if (halted0 !== 1'b1 || cause0 !== 2'b01 || cnt0 !== 32'd4) begin
            n_fail++;
            $display("FAIL prog_halt got h=%b c=%b n=%0d want h=1 c=01 n=4",
                     halted0, cause0, cnt0);
        end
        for (int i = 0; i < 3; i++) tick(0, 1, 1, 0, 1, 0);
        n_checks++;
        if (pc0 !== 32'hC || obs_en !== 1'b0 || halted0 !== 1'b1) begin
            n_fail++;
            $display("FAIL prog_hold got pc=%h en=%b h=%b want pc=0000000c en=0 h=1",
                     pc0, obs_en, halted0);
        end
    endtask

    task automatic test_budget();
        int commits;
        int guard;
        tick(1, 0, 0, 0, 1, 0);
        tick(0, 1, 0, 0, 1, 0);
        commits = 0;
        guard = 0;
        while (!halted2 && guard < 20) begin
            tick(0, 0, 0, 0, 1, 0);
            if (obs_en2) commits++;
            guard++;
        end
        for (int i = 0; i < 2; i++) begin
            tick(0, 1, 0, 0, 1, 0);
            if (obs_en2) commits++;
        end
        n_checks++;
        if (halted2 !== 1'b1 || cause2 !== 2'b10) begin
            n_fail++;
            $display("FAIL budget_halt got h=%b c=%b want h=1 c=10", halted2, cause2);
        end
        n_checks++;
        if (cnt2 !== 32'd2 || pc2 !== 32'h8 || commits != 2) begin
            n_fail++;
            $display("FAIL budget_cnt got n=%0d pc=%h commits=%0d want 2 00000008 2",
                     cnt2, pc2, commits);
        end
    endtask

    task automatic test_step();
        int per;
        tick(1, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            per = 0;
            tick(0, 0, 1, 0, 1, 0);
            if (obs_en) per++;
            for (int j = 0; j < 2; j++) begin
                tick(0, 0, 0, 0, 1, 0);
                if (obs_en) per++;
            end
            n_checks++;
            if (per != 1 || running0 !== 1'b0 || halted0 !== 1'b0) begin
                n_fail++;
                $display("FAIL step%0d got en_cycles=%0d run=%b h=%b want 1 0 0",
                         k, per, running0, halted0);
            end
        end
        n_checks++;
        if (pc0 !== 32'hC || cnt0 !== 32'd3) begin
            n_fail++;
            $display("FAIL step_end got pc=%h n=%0d want 0000000c 3", pc0, cnt0);
        end
    endtask

    task automatic test_pause();
        tick(1, 0, 0, 0, 1, 0);
        tick(0, 1, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 0, 1, 1, 0);
            n_checks++;
            if (obs_en !== 1'b0 || pc0 !== 32'h4 || running0 !== 1'b0) begin
                n_fail++;
                $display("FAIL pause%0d got en=%b pc=%h run=%b want 0 00000004 0",
                         i, obs_en, pc0, running0);
            end
        end
        tick(0, 1, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1, 0);
        n_checks++;
        if (obs_en !== 1'b1 || pc0 !== 32'h8) begin
            n_fail++;
            $display("FAIL resume got en=%b pc=%h want 1 00000008", obs_en, pc0);
        end
    endtask

    task automatic test_fault();
        tick(1, 0, 0, 0, 1, 0);
        tick(0, 1, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 32'h6);
        n_checks++;
        if (fault0 !== 1'b1 || pc0 !== 32'h4 || cnt0 !== 32'd1 || obs_en !== 1'b0) begin
            n_fail++;
            $display("FAIL fault got f=%b pc=%h n=%0d en=%b want 1 00000004 1 0",
                     fault0, pc0, cnt0, obs_en);
        end
        tick(0, 1, 0, 0, 1, 0);
        tick(0, 0, 1, 0, 1, 0);
        n_checks++;
        if (fault0 !== 1'b1 || running0 !== 1'b0 || pc0 !== 32'h4) begin
            n_fail++;
            $display("FAIL fault_sticky got f=%b run=%b pc=%h want 1 0 00000004",
                     fault0, running0, pc0);
        end
    endtask

    task automatic test_rst_mid();
        tick(1, 0, 0, 0, 1, 0);
        tick(0, 1, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1, 0);
        n_checks++;
        if (pc0 !== 32'h8) begin
            n_fail++; $display("FAIL rst_setup got pc=%h want 00000008", pc0);
        end
        tick(1, 1, 0, 0, 1, 0);
        n_checks++;
        if (pc0 !== 32'h0 || cnt0 !== 32'd0 ||
            {running0, halted0, fault0, cause0} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_mid got pc=%h n=%0d flags=%b want 0 0 00000",
                     pc0, cnt0, {running0, halted0, fault0, cause0});
        end
    endtask

    task automatic test_random();
        logic        r, s, st, pr;
        logic [31:0] npc;
        int          sel;
        tick(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 4) == 0);
            pr = ($urandom_range(0, 4) == 0);
            sel = $urandom_range(0, 19);
            if (sel < 14)       npc = pc0 + 32'd4;
            else if (sel < 15)  npc = pc0;
            else if (sel < 16)  npc = pc0 + 32'd2 + {31'd0, 1'($urandom)};
            else                npc = $urandom & 32'hFFFF_FFFC;
            tick(r, s, st, pr, 0, npc);
            n_checks++;
            if (obs_en !== exp_en || pc0 !== m_pc || cnt0 !== m_cnt ||
                running0 !== (m_state == M_RUN || m_state == M_STEP) ||
                halted0 !== (m_state == M_HALT) ||
                fault0 !== (m_state == M_FAULT) || cause0 !== m_cause) begin
                n_fail++;
                $display("FAIL rand%0d got en=%b pc=%h n=%0d rhf=%b%b%b c=%b want en=%b pc=%h n=%0d st=%0d c=%b",
                         i, obs_en, pc0, cnt0, running0, halted0, fault0, cause0,
                         exp_en, m_pc, m_cnt, m_state, m_cause);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; step = 1'b0; pause_req = 1'b0;
        next_pc0 = 32'h4;
        m_state = M_PAUSE; m_pc = 32'h0; m_cnt = 32'h0; m_cause = 2'b00;
        @(negedge clk);
        test_reset();
        test_program();
        test_budget();
        test_step();
        test_pause();
        test_fault();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
